// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are registered.
module sync_fifo #(
  parameter int DW     = 4,
  parameter int AW     = 2,
  parameter int AF_LVL = 2**AW-1,
  parameter int AE_LVL = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] dat_i,
  input  logic          pop_i,
  output logic [DW-1:0] dat_o,
  output logic          valid_o,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count_o,
  output logic          ovf_o,
  output logic          udf_o,
  input  logic          clr_err_i
);

  localparam int          DEPTH = 2**AW;
  localparam logic [AW:0] AF_C  = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AE_C  = (AW+1)'(AE_LVL);

`ifndef SYNTHESIS
  if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_af_chk
    $error("sync_fifo: AF_LVL=%0d outside 1..%0d", AF_LVL, DEPTH);
  end
  if (AE_LVL < 0 || AE_LVL > DEPTH-1) begin : g_ae_chk
    $error("sync_fifo: AE_LVL=%0d outside 0..%0d", AE_LVL, DEPTH-1);
  end
`endif

  logic [DW-1:0] mem_q [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        af_q, af_d;
  logic        ae_q, ae_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;
  logic        push_ok, pop_ok;

  always_comb begin
    push_ok  = push_i && !full_q;
    pop_ok   = pop_i && !empty_q;
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    // Pointer MSBs disambiguate full from empty when the indices coincide.
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    af_d     = (count_d >= AF_C);
    ae_d     = (count_d <= AE_C);
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clr_err_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (push_i && full_q) ovf_d = 1'b1;
    if (pop_i && empty_q) udf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is left uninitialised on reset; the pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) mem_q[wr_ptr_q[AW-1:0]] <= dat_i;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dat_o   = empty_q ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign valid_o = !empty_q;
`else
  logic [DW-1:0] dat_q;
  logic          valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dat_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= pop_ok;
      if (pop_ok) dat_q <= mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  assign dat_o   = dat_q;
  assign valid_o = valid_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count_o      = count_q;
  assign ovf_o        = ovf_q;
  assign udf_o        = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DW=4, AW=2): expected read words go into a scoreboard
// queue that an independent monitor drains whenever the DUT presents output data.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       push_i = 1'b0;
  logic [3:0] dat_i = 4'h0;
  logic       pop_i = 1'b0;
  logic       clr_err_i = 1'b0;
  logic [3:0] dat_o;
  logic       valid_o, full, empty, almost_full, almost_empty, ovf_o, udf_o;
  logic [2:0] count_o;

  int n_pass = 0;
  int n_total = 0;
  logic [3:0] exp_q [$];

  always #5 clk = ~clk;

  sync_fifo dut (
    .clk_i(clk), .rst_i(rst_i), .push_i(push_i), .dat_i(dat_i), .pop_i(pop_i),
    .dat_o(dat_o), .valid_o(valid_o), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count_o(count_o),
    .ovf_o(ovf_o), .udf_o(udf_o), .clr_err_i(clr_err_i)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic cyc(input logic p, input logic [3:0] d, input logic q, input logic c);
    push_i = p; dat_i = d; pop_i = q; clr_err_i = c;
    @(posedge clk); #1;
    push_i = 1'b0; pop_i = 1'b0; clr_err_i = 1'b0;
  endtask

  task automatic pop_exp(input logic [3:0] v);
    exp_q.push_back(v);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
  endtask

  task automatic chk_state(input string tag, input int cnt, input int f, input int e,
                           input int af, input int ae);
    chk({tag, "_count"}, int'(count_o), cnt);
    chk({tag, "_full"}, int'(full), f);
    chk({tag, "_empty"}, int'(empty), e);
    chk({tag, "_afull"}, int'(almost_full), af);
    chk({tag, "_aempty"}, int'(almost_empty), ae);
  endtask

  task automatic chk_reset(input string tag);
    chk_state(tag, 0, 0, 1, 0, 1);
    chk({tag, "_valid"}, int'(valid_o), 0);
    chk({tag, "_dat"}, int'(dat_o), 0);
    chk({tag, "_ovf"}, int'(ovf_o), 0);
    chk({tag, "_udf"}, int'(udf_o), 0);
  endtask

  // Scoreboard monitor: one line per observed read transaction.
  always @(negedge clk) begin
`ifdef SYNC_FIFO_FWFT_EN
    if (valid_o === 1'b1 && pop_i === 1'b1) begin
`else
    if (valid_o === 1'b1) begin
`endif
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_read: got dat_o=0x%0h, expected no read", dat_o);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        $display("read: dat_o=0x%0h expected=0x%0h", dat_o, e);
        chk("read_dat", int'(dat_o), int'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); @(posedge clk); #1;
    rst_i = 1'b0;
    chk_reset("reset");

    // Fill to full
    cyc(1'b1, 4'h1, 1'b0, 1'b0); chk_state("fill1", 1, 0, 0, 0, 1);
    cyc(1'b1, 4'h2, 1'b0, 1'b0); chk_state("fill2", 2, 0, 0, 0, 0);
    cyc(1'b1, 4'h3, 1'b0, 1'b0); chk_state("fill3", 3, 0, 0, 1, 0);
    cyc(1'b1, 4'h4, 1'b0, 1'b0); chk_state("fill4", 4, 1, 0, 1, 0);
    chk("fill_ovf", int'(ovf_o), 0);

    // Push while full with a simultaneous pop: pop wins, push rejected
    exp_q.push_back(4'h1);
    cyc(1'b1, 4'h5, 1'b1, 1'b0);
    chk_state("ovf", 3, 0, 0, 1, 0);
    chk("ovf_flag", int'(ovf_o), 1);

    // Drain and underflow
    pop_exp(4'h2);
    pop_exp(4'h3);
    pop_exp(4'h4);
    chk_state("drained", 0, 0, 1, 0, 1);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    chk("idle_valid", int'(valid_o), 0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("udf_flag", int'(udf_o), 1);
    chk("udf_valid", int'(valid_o), 0);
    chk("udf_count", int'(count_o), 0);
    chk("udf_ovf_sticky", int'(ovf_o), 1);

    // Error clear, and set beating clear
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    chk("clr_ovf", int'(ovf_o), 0);
    chk("clr_udf", int'(udf_o), 0);
    cyc(1'b0, 4'h0, 1'b1, 1'b1);
    chk("clr_vs_udf", int'(udf_o), 1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    chk("clr2_udf", int'(udf_o), 0);

    // Wrap with simultaneous push+pop, occupancy held at 2
    cyc(1'b1, 4'h0, 1'b0, 1'b0);
    cyc(1'b1, 4'h1, 1'b0, 1'b0);
    chk("wrap_pre_count", int'(count_o), 2);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(4'(i));
      cyc(1'b1, 4'(i + 2), 1'b1, 1'b0);
      chk($sformatf("wrap%0d_count", i), int'(count_o), 2);
    end
    chk("wrap_ovf", int'(ovf_o), 0);
    chk("wrap_udf", int'(udf_o), 0);
    chk("wrap_full", int'(full), 0);
    chk("wrap_empty", int'(empty), 0);

    // Rejected push with clr_err_i in the same cycle
    cyc(1'b1, 4'hC, 1'b0, 1'b0);
    cyc(1'b1, 4'hD, 1'b0, 1'b0);
    chk_state("refill", 4, 1, 0, 1, 0);
    cyc(1'b1, 4'hF, 1'b0, 1'b1);
    chk("clr_vs_ovf", int'(ovf_o), 1);
    chk("clr_vs_ovf_count", int'(count_o), 4);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    chk("clr3_ovf", int'(ovf_o), 0);
    pop_exp(4'hA);
    chk("pre_rst_count", int'(count_o), 3);

    // Mid-operation reset discards contents
    rst_i = 1'b1;
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    rst_i = 1'b0;
    chk_reset("midrst");

    cyc(1'b1, 4'hA, 1'b0, 1'b0);
    chk("post_push_count", int'(count_o), 1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("post_push_valid", int'(valid_o), 1);
    chk("post_push_dat", int'(dat_o), 10);
`else
    chk("post_push_valid", int'(valid_o), 0);
`endif
    pop_exp(4'hA);
    chk("post_pop_count", int'(count_o), 0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised synchronous FIFO with an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It is the next generation of the FIFO in the fifo sub-design. It replaces the fixed push-button-driven FIFO with a handshake-driven buffer that sits between any producer and consumer in the `clk_i` domain. Read mode is registered by default; first-word-fall-through is a compile-time option.

## Interface
Parameters:
- `DW`, 4, data width in bits.
- `AW`, 2, address width; depth = 2**AW entries.
- `AF_LVL`, 2**AW-1, `almost_full` asserts when count >= AF_LVL.
- `AE_LVL`, 1, `almost_empty` asserts when count <= AE_LVL.

Ports:
- `clk_i` in 1: the single clock; all logic on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `push_i` in 1: write request.
- `dat_i` in DW: write data, sampled when a push is accepted.
- `pop_i` in 1: read request.
- `dat_o` out DW: read data.
- `valid_o` out 1: `dat_o` holds a popped word (registered mode) or the head word (FWFT mode).
- `full` out 1: count == 2**AW.
- `empty` out 1: count == 0.
- `almost_full` out 1: count >= AF_LVL.
- `almost_empty` out 1: count <= AE_LVL.
- `count_o` out AW+1: current occupancy, 0..2**AW.
- `ovf_o` out 1: sticky; a push was rejected.
- `udf_o` out 1: sticky; a pop was rejected.
- `clr_err_i` in 1: clears `ovf_o` and `udf_o`.

## Operation
- Storage: 2**AW x DW register array. Write and read pointers are AW+1 bits wide and wrap modulo 2**(AW+1); the array index is ptr[AW-1:0].
- Push acceptance: `push_i && !full`. A push while full is rejected, even if a pop is accepted in the same cycle; the rejection sets `ovf_o`.
- Pop acceptance: `pop_i && !empty`. A pop while empty is rejected, even if a push is accepted in the same cycle; the rejection sets `udf_o`.
- Count update: count += accepted push − accepted pop. Simultaneous accepted push and pop leaves count unchanged and advances both pointers.
- Flag timing: all status flags are registered and derived from the next-cycle count, so they are valid in the same cycle as `count_o`.
- Error flags: set has priority over `clr_err_i` in the same cycle. Flags hold until cleared or reset.
- Rejected requests do not change pointers, count, `dat_o` or the array.
- Parameter check: AF_LVL must be in 1..2**AW and AE_LVL in 0..2**AW-1. The design checks this at elaboration with `$error` under simulation.

## Timing
- Reset (takes effect on the next rising edge while `rst_i`=1): pointers=0, count_o=0, dat_o=0, valid_o=0, empty=1, full=0, almost_empty=1 (for AE_LVL ≥ 0), almost_full=0, ovf_o=0, udf_o=0.
- Reset mid-operation discards all stored data. Array contents need not be cleared.
- Push latency: a word pushed at edge N is counted at N (count_o updates after N). In registered mode it is poppable from edge N+1.
- Registered-mode pop: pop accepted at edge N → `dat_o` = head word and `valid_o`=1 during the cycle after N. `valid_o` is 0 in cycles with no accepted pop, and `dat_o` holds its last value.
- Wrap-around: after 2**AW pushes the write index returns to 0. full/empty are distinguished by pointer MSB inequality/equality, consistent with count_o.

## Configuration
- `SYNC_FIFO_FWFT_EN` defined: first-word-fall-through mode.
  - `dat_o` shows the head word combinationally from the array whenever `!empty`, and `valid_o` = `!empty`.
  - A pop accepted at edge N advances the read pointer, so the next word (if any) appears after N.
  - Read latency is 0.
  - Push-to-visible latency is 1 cycle: data written at edge N shows on `dat_o` after N.
- Not defined: registered read mode as described under Timing.

## Test plan
- Reset and fill (DW=4, AW=2): reset, then push 0x1,0x2,0x3,0x4 on consecutive edges → count_o 1,2,3,4; almost_full at count 3; full=1 after the 4th push; ovf_o=0.
- Overflow while full: push 0x5 while full, with pop_i=1 in the same cycle → pop accepted, push rejected, ovf_o=1, count_o=3. Pops then return 0x1..0x4 in order; 0x5 never appears.
- Drain and underflow: pop 4 words → registered-mode dat_o 0x1,0x2,0x3,0x4 with valid_o one cycle after each pop; empty=1. A further pop → udf_o=1, valid_o=0, count_o=0.
- Error clear: pulse clr_err_i=1 → ovf_o=0, udf_o=0. clr_err_i asserted in the same cycle as a rejected push → ovf_o=1.
- Wrap and simultaneous traffic: 10 cycles of push+pop with count held at 2, using data 0..9 → count_o stays 2, pointers wrap, output order matches input order, no error flags.
- Mid-operation reset with count=3: assert rst_i for one edge → all outputs at reset values. The next push/pop of 0xA returns 0xA (with `SYNC_FIFO_FWFT_EN`: dat_o=0xA and valid_o=1 one cycle after the push).
